pck_inj_scheduler: RTL and testbench

//  Shares one endpoint packet-injector control interface (pck_injct_in/out) among NR local

---
 rtl/pck_inj_scheduler_pkg.sv | 18 +
 rtl/pck_inj_scheduler_arb.sv | 36 +++
 rtl/pck_inj_scheduler.sv | 165 ++++++++++++++++
 tb/tb_pck_inj_scheduler.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pck_inj_scheduler_pkg.sv
// Shared types and width helpers for the endpoint packet-injector scheduler.
// Holds the scheduler FSM state encoding and the saturation limit for its counters.
package pck_inj_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIssue  = 2'd1,
    StSettle = 2'd2
  } pck_inj_sched_state_t;

  localparam logic [15:0] SAT16 = 16'hFFFF;

  // Index width that never collapses to zero bits for single-entry fields.
  function automatic int unsigned calc_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pck_inj_scheduler_arb.sv
// Combinational round-robin arbiter: first request strictly after i_ptr wins, with wrap.
// Produces a one-hot grant, its index and an any-request flag.
module rr_mask_arbiter #(
  parameter int unsigned NR = 4,
  parameter int unsigned IW = 2
) (
  input  logic [NR-1:0] i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [NR-1:0] o_gnt,
  output logic [IW-1:0] o_gnt_idx,
  output logic          o_any
);

  logic [NR-1:0] w_mask;
  logic [NR-1:0] w_masked;
  logic [NR-1:0] w_pick;

  always_comb begin
    for (int unsigned i = 0; i < NR; i++) begin
      w_mask[i] = (IW'(i) > i_ptr);
    end
    w_masked = i_req & w_mask;
    // Fall back to the unmasked set once nothing remains above the pointer.
    w_pick   = (|w_masked) ? w_masked : i_req;
    o_gnt    = w_pick & (~w_pick + NR'(1));
    o_any    = |i_req;
  end

  always_comb begin
    o_gnt_idx = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (o_gnt[i]) o_gnt_idx = IW'(i);
    end
  end

endmodule

// File: rtl/pck_inj_scheduler.sv
// Shares one endpoint packet-injector among NR requesters: VC-ready-gated round-robin grant,
// one-cycle inject pulse, then GAP settle cycles before the next grant.
module pck_inj_scheduler
  import pck_inj_scheduler_pkg::*;
#(
  parameter int unsigned NR      = 4,
  parameter int unsigned V       = 2,
  parameter int unsigned C       = 1,
  parameter int unsigned EAw     = 8,
  parameter int unsigned DW      = 128,
  parameter int unsigned PSw     = 5,
  parameter int unsigned MIN_PCK = 2,
  parameter int unsigned MAX_PCK = 20,
  parameter int unsigned GAP     = 1,
  localparam int unsigned VW     = calc_w(V),
  localparam int unsigned CW     = calc_w(C),
  localparam int unsigned IW     = calc_w(NR)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NR-1:0]      i_req_valid,
  output logic [NR-1:0]      o_req_ready,
  input  logic [NR*EAw-1:0]  i_req_dest,
  input  logic [NR*PSw-1:0]  i_req_size,
  input  logic [NR*VW-1:0]   i_req_vc,
  input  logic [NR*CW-1:0]   i_req_class,
  input  logic [NR*DW-1:0]   i_req_data,
  input  logic [V-1:0]       i_inj_ready,
  output logic               o_inj_wr,
  output logic [EAw-1:0]     o_inj_dest,
  output logic [PSw-1:0]     o_inj_size,
  output logic [V-1:0]       o_inj_vc,
  output logic [CW-1:0]      o_inj_class,
  output logic [DW-1:0]      o_inj_data,
  output logic [NR*16-1:0]   o_sent_cnt,
  output logic [15:0]        o_drop_cnt,
  output logic               o_busy
);

  pck_inj_sched_state_t r_state, w_state_d;

  logic [IW-1:0]    r_ptr, r_gnt_idx, w_gnt_idx;
  logic [NR-1:0]    w_elig, w_vc_bad, w_gnt;
  logic             w_any, w_legal, w_take;
  logic [VW-1:0]    w_vc [NR];
  logic [VW-1:0]    w_sel_vc;
  logic [V-1:0]     w_sel_vc_oh;
  logic [PSw-1:0]   w_sel_size;
  logic [15:0]      w_cur_sent;
  logic [2:0]       r_gap_cnt;
  logic [EAw-1:0]   r_dest;
  logic [PSw-1:0]   r_size;
  logic [V-1:0]     r_vc_oh;
  logic [CW-1:0]    r_class;
  logic [DW-1:0]    r_data;
  logic [NR*16-1:0] r_sent_cnt;
  logic [15:0]      r_drop_cnt;

  // Out-of-range VCs stay eligible so they get consumed and counted as drops.
  always_comb begin
    for (int unsigned r = 0; r < NR; r++) begin
      w_vc[r]     = i_req_vc[r*VW +: VW];
      w_vc_bad[r] = (32'(w_vc[r]) >= V);
      w_elig[r]   = i_req_valid[r] & (w_vc_bad[r] | i_inj_ready[w_vc[r]]);
    end
  end

  rr_mask_arbiter #(
    .NR (NR),
    .IW (IW)
  ) u_arb (
    .i_req     (w_elig),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  always_comb begin
    w_sel_size = i_req_size[32'(w_gnt_idx)*PSw +: PSw];
    w_sel_vc   = w_vc[w_gnt_idx];
    for (int unsigned v = 0; v < V; v++) begin
      w_sel_vc_oh[v] = !w_vc_bad[w_gnt_idx] && (32'(w_sel_vc) == v);
    end
    w_legal    = !w_vc_bad[w_gnt_idx] && (32'(w_sel_size) >= MIN_PCK) &&
                 (32'(w_sel_size) <= MAX_PCK);
    w_take     = (r_state == StIdle) && w_any;
    w_cur_sent = r_sent_cnt[32'(r_gnt_idx)*16 +: 16];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= StIdle;
    else         r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:   if (w_take && w_legal) w_state_d = StIssue;
      StIssue:  w_state_d = (GAP == 0) ? StIdle : StSettle;
      StSettle: if (r_gap_cnt <= 3'd1) w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_comb begin
    o_req_ready = (r_state == StIdle) ? w_gnt : '0;
    o_inj_wr    = (r_state == StIssue);
    o_busy      = (r_state != StIdle);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_gap_cnt <= '0;
    end else if (r_state == StIssue) begin
      r_gap_cnt <= 3'(GAP);
    end else if (r_state == StSettle && r_gap_cnt != 3'd0) begin
      r_gap_cnt <= r_gap_cnt - 3'd1;
    end
  end

  // Fields are captured on every grant, including drops, and hold until the next one.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr     <= IW'(NR - 1);
      r_gnt_idx <= '0;
      r_dest    <= '0;
      r_size    <= '0;
      r_vc_oh   <= '0;
      r_class   <= '0;
      r_data    <= '0;
    end else if (w_take) begin
      r_ptr     <= w_gnt_idx;
      r_gnt_idx <= w_gnt_idx;
      r_dest    <= i_req_dest[32'(w_gnt_idx)*EAw +: EAw];
      r_size    <= w_sel_size;
      r_vc_oh   <= w_sel_vc_oh;
      r_class   <= i_req_class[32'(w_gnt_idx)*CW +: CW];
      r_data    <= i_req_data[32'(w_gnt_idx)*DW +: DW];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sent_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (r_state == StIssue && w_cur_sent != SAT16) begin
        r_sent_cnt[32'(r_gnt_idx)*16 +: 16] <= w_cur_sent + 16'd1;
      end
      if (w_take && !w_legal && r_drop_cnt != SAT16) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign o_inj_dest  = r_dest;
  assign o_inj_size  = r_size;
  assign o_inj_vc    = r_vc_oh;
  assign o_inj_class = r_class;
  assign o_inj_data  = r_data;
  assign o_sent_cnt  = r_sent_cnt;
  assign o_drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_pck_inj_scheduler.sv
// Self-checking bench for pck_inj_scheduler: directed scenarios plus randomized traffic,
// all compared against a transaction-level reference model kept in this file.
module tb_pck_inj_scheduler;

  localparam int unsigned NR = 4, V = 2, C = 1, EAw = 8, DW = 128, PSw = 5;
  localparam int unsigned MIN_PCK = 2, MAX_PCK = 20, GAP = 1, VW = 1, CW = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid, req_ready;
  logic [NR*EAw-1:0] req_dest;
  logic [NR*PSw-1:0] req_size;
  logic [NR*VW-1:0]  req_vc;
  logic [NR*CW-1:0]  req_class;
  logic [NR*DW-1:0]  req_data;
  logic [V-1:0]      inj_ready;
  logic              inj_wr, busy;
  logic [EAw-1:0]    inj_dest;
  logic [PSw-1:0]    inj_size;
  logic [V-1:0]      inj_vc;
  logic [CW-1:0]     inj_class;
  logic [DW-1:0]     inj_data;
  logic [NR*16-1:0]  sent_cnt;
  logic [15:0]       drop_cnt;

  always #5 clk = ~clk;

  pck_inj_scheduler #(
    .NR (NR), .V (V), .C (C), .EAw (EAw), .DW (DW), .PSw (PSw),
    .MIN_PCK (MIN_PCK), .MAX_PCK (MAX_PCK), .GAP (GAP)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_dest  (req_dest),
    .i_req_size  (req_size),
    .i_req_vc    (req_vc),
    .i_req_class (req_class),
    .i_req_data  (req_data),
    .i_inj_ready (inj_ready),
    .o_inj_wr    (inj_wr),
    .o_inj_dest  (inj_dest),
    .o_inj_size  (inj_size),
    .o_inj_vc    (inj_vc),
    .o_inj_class (inj_class),
    .o_inj_data  (inj_data),
    .o_sent_cnt  (sent_cnt),
    .o_drop_cnt  (drop_cnt),
    .o_busy      (busy)
  );

  // Reference model: pointer, remaining non-idle cycles, pending inject, counters, held fields.
  int             m_ptr, m_hold, m_gnt;
  bit             m_issue;
  logic [15:0]    m_sent [NR];
  logic [15:0]    m_drop;
  logic [EAw-1:0] m_dest;
  logic [PSw-1:0] m_size;
  logic [V-1:0]   m_vc_oh;
  logic [CW-1:0]  m_class;
  logic [DW-1:0]  m_data;

  logic [NR-1:0]  obs_rdy, exp_rdy;
  logic           obs_wr, exp_wr, obs_busy, exp_busy;
  int             n_checks = 0;
  int             n_pass = 0;

  task automatic m_reset();
    m_ptr = NR - 1; m_hold = 0; m_gnt = 0; m_issue = 0; m_drop = '0;
    for (int r = 0; r < NR; r++) m_sent[r] = '0;
    m_dest = '0; m_size = '0; m_vc_oh = '0; m_class = '0; m_data = '0;
  endtask

  task automatic set_req(input int r, input logic v, input logic [EAw-1:0] d,
                         input logic [PSw-1:0] s, input logic [VW-1:0] vc);
    req_valid[r]             = v;
    req_dest[r*EAw +: EAw]   = d;
    req_size[r*PSw +: PSw]   = s;
    req_vc[r*VW +: VW]       = vc;
    req_class[r*CW +: CW]    = CW'($urandom_range(0, 1));
    req_data[r*DW +: DW]     = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic clear_reqs();
    req_valid = '0;
  endtask

  // One clock: sample DUT and model predictions before the edge, advance the model at the edge.
  task automatic tick();
    int g, v, s;
    #1;
    g = -1;
    exp_rdy = '0;
    if (m_hold == 0) begin
      for (int k = 1; k <= NR; k++) begin
        int r;
        r = (m_ptr + k) % NR;
        v = int'(req_vc[r*VW +: VW]);
        if (g < 0 && req_valid[r] && (v >= V || inj_ready[v])) begin
          g = r;
          exp_rdy[r] = 1'b1;
        end
      end
    end
    exp_wr   = m_issue;
    exp_busy = (m_hold != 0);
    obs_rdy  = req_ready;
    obs_wr   = inj_wr;
    obs_busy = busy;
    @(posedge clk);
    if (reset) begin
      m_reset();
    end else begin
      if (m_issue) begin
        if (m_sent[m_gnt] != 16'hFFFF) m_sent[m_gnt] = m_sent[m_gnt] + 16'd1;
        m_issue = 0;
      end
      if (m_hold > 0) m_hold--;
      if (g >= 0) begin
        v       = int'(req_vc[g*VW +: VW]);
        s       = int'(req_size[g*PSw +: PSw]);
        m_ptr   = g;
        m_dest  = req_dest[g*EAw +: EAw];
        m_size  = req_size[g*PSw +: PSw];
        m_vc_oh = (v < V) ? V'(1 << v) : '0;
        m_class = req_class[g*CW +: CW];
        m_data  = req_data[g*DW +: DW];
        if (v < V && s >= MIN_PCK && s <= MAX_PCK) begin
          m_issue = 1; m_hold = 1 + GAP; m_gnt = g;
        end else if (m_drop != 16'hFFFF) begin
          m_drop = m_drop + 16'd1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_reqs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    inj_ready = '0;
    do_reset();
    #1;
    n_checks++; if (inj_wr !== 1'b0) $display("FAIL reset_wr: got %b want 0", inj_wr); else n_pass++;
    n_checks++; if (req_ready !== '0) $display("FAIL reset_ready: got %b want 0", req_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (sent_cnt !== '0) $display("FAIL reset_sent: got %h want 0", sent_cnt); else n_pass++;
    n_checks++; if (drop_cnt !== '0) $display("FAIL reset_drop: got %h want 0", drop_cnt); else n_pass++;
    n_checks++;
    if ({inj_dest, inj_size, inj_vc, inj_class} !== '0 || inj_data !== '0)
      $display("FAIL reset_fields: got %h/%h/%b/%h want 0", inj_dest, inj_size, inj_vc, inj_data);
    else n_pass++;
  endtask

  task automatic test_single();
    inj_ready = 2'b11;
    clear_reqs();
    set_req(0, 1'b1, 8'd3, 5'd4, 1'b0);
    tick();
    n_checks++; if (obs_rdy !== 4'b0001) $display("FAIL single_ready: got %b want 0001", obs_rdy); else n_pass++;
    clear_reqs();
    #1;
    n_checks++; if (inj_wr !== 1'b1) $display("FAIL single_wr: got %b want 1", inj_wr); else n_pass++;
    n_checks++; if (inj_dest !== 8'd3) $display("FAIL single_dest: got %0d want 3", inj_dest); else n_pass++;
    n_checks++; if (inj_size !== 5'd4) $display("FAIL single_size: got %0d want 4", inj_size); else n_pass++;
    n_checks++; if (inj_vc !== 2'b01) $display("FAIL single_vc: got %b want 01", inj_vc); else n_pass++;
    n_checks++; if (inj_data !== m_data) $display("FAIL single_data: got %h want %h", inj_data, m_data); else n_pass++;
    tick();
    tick();
    n_checks++; if (obs_busy !== 1'b1) $display("FAIL single_settle_busy: got %b want 1", obs_busy); else n_pass++;
    tick();
    n_checks++; if (sent_cnt[15:0] !== 16'd1) $display("FAIL single_sent: got %0d want 1", sent_cnt[15:0]); else n_pass++;
    n_checks++; if (inj_dest !== 8'd3) $display("FAIL single_hold_dest: got %0d want 3", inj_dest); else n_pass++;
  endtask

  task automatic test_round_robin();
    int order[$];
    int wr_cyc[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    inj_ready = 2'b11;
    for (int r = 0; r < NR; r++)
      set_req(r, 1'b1, 8'($urandom), 5'($urandom_range(MIN_PCK, MAX_PCK)), 1'($urandom));
    for (int c = 0; c < 16; c++) begin
      tick();
      n_checks++;
      if (obs_rdy !== exp_rdy) $display("FAIL rr_ready c%0d: got %b want %b", c, obs_rdy, exp_rdy);
      else n_pass++;
      n_checks++;
      if (obs_wr !== exp_wr) $display("FAIL rr_wr c%0d: got %b want %b", c, obs_wr, exp_wr);
      else n_pass++;
      if (obs_wr === 1'b1) wr_cyc.push_back(c);
      for (int r = 0; r < NR; r++) begin
        if (obs_rdy[r] === 1'b1) begin
          order.push_back(r);
          set_req(r, 1'b1, 8'($urandom), 5'($urandom_range(MIN_PCK, MAX_PCK)), 1'($urandom));
        end
      end
    end
    n_checks++;
    if (order.size() < 5) $display("FAIL rr_grant_count: got %0d want >=5", order.size());
    else n_pass++;
    for (int i = 0; i < 5 && i < order.size(); i++) begin
      n_checks++;
      if (order[i] != exp_order[i]) $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], exp_order[i]);
      else n_pass++;
    end
    for (int i = 1; i < 4 && i < wr_cyc.size(); i++) begin
      n_checks++;
      if (wr_cyc[i] - wr_cyc[i-1] != 2 + GAP)
        $display("FAIL rr_interval[%0d]: got %0d want %0d", i, wr_cyc[i] - wr_cyc[i-1], 2 + GAP);
      else n_pass++;
    end
    clear_reqs();
  endtask

  task automatic test_vc_skip();
    do_reset();
    inj_ready = 2'b01;
    set_req(0, 1'b1, 8'd10, 5'd6, 1'b1);
    set_req(1, 1'b1, 8'd11, 5'd7, 1'b0);
    tick();
    n_checks++; if (obs_rdy !== 4'b0010) $display("FAIL vc_first: got %b want 0010", obs_rdy); else n_pass++;
    req_valid[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (obs_rdy !== 4'b0000) $display("FAIL vc_blocked c%0d: got %b want 0000", c, obs_rdy);
      else n_pass++;
    end
    inj_ready = 2'b11;
    tick();
    n_checks++; if (obs_rdy !== 4'b0001) $display("FAIL vc_second: got %b want 0001", obs_rdy); else n_pass++;
    clear_reqs();
    #1;
    n_checks++; if (inj_vc !== 2'b10) $display("FAIL vc_onehot: got %b want 10", inj_vc); else n_pass++;
    tick();
  endtask

  task automatic test_illegal();
    do_reset();
    inj_ready = 2'b11;
    set_req(2, 1'b1, 8'd5, 5'd1, 1'b0);
    tick();
    n_checks++; if (obs_rdy !== 4'b0100) $display("FAIL ill_ready1: got %b want 0100", obs_rdy); else n_pass++;
    req_size[2*PSw +: PSw] = 5'd21;
    tick();
    n_checks++; if (obs_rdy !== 4'b0100) $display("FAIL ill_ready2: got %b want 0100", obs_rdy); else n_pass++;
    clear_reqs();
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (obs_wr !== 1'b0) $display("FAIL ill_wr c%0d: got %b want 0", c, obs_wr); else n_pass++;
    end
    n_checks++; if (drop_cnt !== 16'd2) $display("FAIL ill_drop: got %0d want 2", drop_cnt); else n_pass++;
    n_checks++; if (sent_cnt !== '0) $display("FAIL ill_sent: got %h want 0", sent_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    inj_ready = 2'b11;
    set_req(2, 1'b1, 8'd1, 5'd5, 1'b0);
    tick();
    clear_reqs();
    tick();
    tick();
    set_req(1, 1'b1, 8'd2, 5'd0, 1'b0);
    tick();
    clear_reqs();
    set_req(0, 1'b1, 8'd4, 5'd6, 1'b1);
    tick();
    n_checks++; if (obs_rdy !== 4'b0001) $display("FAIL rst_pre_grant: got %b want 0001", obs_rdy); else n_pass++;
    clear_reqs();
    reset = 1'b1;
    tick();
    n_checks++; if (obs_wr !== 1'b1) $display("FAIL rst_issue_wr: got %b want 1", obs_wr); else n_pass++;
    reset = 1'b0;
    for (int r = 0; r < NR; r++) set_req(r, 1'b1, 8'($urandom), 5'd8, 1'b0);
    #1;
    n_checks++; if (inj_wr !== 1'b0) $display("FAIL rst_wr: got %b want 0", inj_wr); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (sent_cnt !== '0) $display("FAIL rst_sent: got %h want 0", sent_cnt); else n_pass++;
    n_checks++; if (drop_cnt !== '0) $display("FAIL rst_drop: got %h want 0", drop_cnt); else n_pass++;
    tick();
    n_checks++; if (obs_rdy !== 4'b0001) $display("FAIL rst_next_grant: got %b want 0001", obs_rdy); else n_pass++;
    clear_reqs();
    tick();
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    inj_ready = 2'b11;
    force dut.r_sent_cnt = {16'h0, 16'h0, 16'hFFFE, 16'h0};
    #1;
    release dut.r_sent_cnt;
    m_sent[1] = 16'hFFFE;
    for (int p = 0; p < 3; p++) begin
      set_req(1, 1'b1, 8'($urandom), 5'd3, 1'b0);
      tick();
      n_checks++;
      if (obs_rdy !== 4'b0010) $display("FAIL sat_ready p%0d: got %b want 0010", p, obs_rdy); else n_pass++;
      clear_reqs();
      tick();
      tick();
      n_checks++;
      if (sent_cnt[31:16] !== m_sent[1]) $display("FAIL sat_cnt p%0d: got %h want %h", p, sent_cnt[31:16], m_sent[1]);
      else n_pass++;
    end
    n_checks++; if (sent_cnt[31:16] !== 16'hFFFF) $display("FAIL sat_final: got %h want ffff", sent_cnt[31:16]); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < NR; r++)
        set_req(r, 1'($urandom_range(0, 9) < 6), 8'($urandom), 5'($urandom), 1'($urandom));
      inj_ready = 2'($urandom);
      tick();
      n_checks++;
      if (obs_rdy !== exp_rdy) $display("FAIL rnd_ready c%0d: got %b want %b", c, obs_rdy, exp_rdy); else n_pass++;
      n_checks++;
      if (obs_wr !== exp_wr) $display("FAIL rnd_wr c%0d: got %b want %b", c, obs_wr, exp_wr); else n_pass++;
      n_checks++;
      if (obs_busy !== exp_busy) $display("FAIL rnd_busy c%0d: got %b want %b", c, obs_busy, exp_busy); else n_pass++;
      #1;
      n_checks++;
      if ({inj_dest, inj_size, inj_vc, inj_class} !== {m_dest, m_size, m_vc_oh, m_class} || inj_data !== m_data)
        $display("FAIL rnd_fields c%0d: got %h/%h/%b want %h/%h/%b", c, inj_dest, inj_size, inj_vc, m_dest, m_size, m_vc_oh);
      else n_pass++;
    end
    clear_reqs();
    tick();
    tick();
    tick();
    for (int r = 0; r < NR; r++) begin
      n_checks++;
      if (sent_cnt[r*16 +: 16] !== m_sent[r]) $display("FAIL rnd_sent[%0d]: got %0d want %0d", r, sent_cnt[r*16 +: 16], m_sent[r]);
      else n_pass++;
    end
    n_checks++; if (drop_cnt !== m_drop) $display("FAIL rnd_drop: got %0d want %0d", drop_cnt, m_drop); else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0; req_dest = '0; req_size = '0; req_vc = '0; req_class = '0; req_data = '0;
    inj_ready = '0;
    m_reset();
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_vc_skip();
    test_illegal();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
